// File: rtl/sm83_bus_responder_if.sv
// SM83 external bus as seen by the target-side responder.
// master = CPU side, slave = responder side.
interface sm83_bus_responder_if;
  logic        mem_cs;
  logic        mem_oe;
  logic        mem_we;
  logic [15:0] addr_bus_ext;
  logic [7:0]  data_bus_wr;
  logic [7:0]  data_bus_rd;
  logic        rd_valid;
  logic        busy;

  modport master (
    output mem_cs, mem_oe, mem_we, addr_bus_ext, data_bus_wr,
    input  data_bus_rd, rd_valid, busy
  );

  modport slave (
    input  mem_cs, mem_oe, mem_we, addr_bus_ext, data_bus_wr,
    output data_bus_rd, rd_valid, busy
  );
endinterface

// File: rtl/sm83_bus_responder.sv
// Decodes SM83 bus cycles onto boot ROM / WRAM / HRAM / boot-disable; read data returns 2 edges after sampling.
// No queueing: requests seen while busy are dropped, next request can be sampled 3 edges after the previous one.
module sm83_bus_responder #(
  parameter int          BOOT_AW  = 8,
  parameter int          WRAM_AW  = 13,
  parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  sm83_bus_responder_if.slave bus,
  output logic               rom_en,
  output logic [BOOT_AW-1:0] rom_addr,
  input  logic [7:0]         rom_dout,
  output logic               wram_en,
  output logic               wram_we,
  output logic [WRAM_AW-1:0] wram_addr,
  output logic [7:0]         wram_din,
  input  logic [7:0]         wram_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [2:0] {REG_NONE, REG_ROM, REG_WRAM, REG_HRAM, REG_BOOT} region_t;

  state_t      state, state_nxt;
  region_t     region_d, region_q;
  logic        req;
  logic [12:0] addr_q;
  logic [7:0]  wdat_q;
  logic        wr_q;
  logic        boot_off;
  logic [7:0]  rd_dat_q;
  logic        rd_vld_q;
  logic [7:0]  rd_mux;
  logic [6:0]  hram_idx;
  logic        access;
  logic [7:0]  hram [0:126];

  assign req = bus.mem_cs && (bus.mem_oe || bus.mem_we);

  always_comb begin
    region_d = REG_NONE;
    if (bus.addr_bus_ext[15:8] == 8'h00)
      region_d = boot_off ? REG_NONE : REG_ROM;
    else if (bus.addr_bus_ext >= 16'hC000 && bus.addr_bus_ext <= 16'hFDFF)
      region_d = REG_WRAM;   // echo range folds onto the same 13 address bits
    else if (bus.addr_bus_ext >= 16'hFF80 && bus.addr_bus_ext != 16'hFFFF)
      region_d = REG_HRAM;
    else if (bus.addr_bus_ext == 16'hFF50)
      region_d = REG_BOOT;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      wdat_q   <= '0;
      wr_q     <= 1'b0;
      region_q <= REG_NONE;
    end else if (state == IDLE && req) begin
      addr_q   <= bus.addr_bus_ext[12:0];
      wdat_q   <= bus.data_bus_wr;
      wr_q     <= bus.mem_we;
      region_q <= region_d;
    end
  end

  assign hram_idx = addr_q[6:0];

  always_comb begin
    rd_mux = OPEN_BUS;
    case (region_q)
      REG_ROM:  rd_mux = rom_dout;
      REG_WRAM: rd_mux = wram_dout;
      REG_HRAM: rd_mux = hram[hram_idx];
      REG_BOOT: rd_mux = {7'h7F, boot_off};
      default:  rd_mux = OPEN_BUS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      boot_off <= 1'b0;
      rd_dat_q <= OPEN_BUS;
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= 1'b0;
      // boot_off is sticky: only a nonzero write sets it, nothing but reset clears it
      if (state == ACCESS && wr_q && region_q == REG_BOOT && wdat_q != 8'h00)
        boot_off <= 1'b1;
      if (state == RESP && !wr_q) begin
        rd_dat_q <= rd_mux;
        rd_vld_q <= 1'b1;
      end
    end
  end

  // HRAM keeps its contents across reset; only the write is suppressed
  always_ff @(posedge clk) begin
    if (!rst && state == ACCESS && wr_q && region_q == REG_HRAM)
      hram[hram_idx] <= wdat_q;
  end

  // rst gating keeps a write from landing in the macro on the aborting edge
  assign access    = (state == ACCESS) && !rst;
  assign rom_en    = access && region_q == REG_ROM && !wr_q;
  assign rom_addr  = addr_q[BOOT_AW-1:0];
  assign wram_en   = access && region_q == REG_WRAM;
  assign wram_we   = wram_en && wr_q;
  assign wram_addr = addr_q[WRAM_AW-1:0];
  assign wram_din  = wdat_q;

  assign bus.busy        = (state != IDLE);
  assign bus.data_bus_rd = rd_dat_q;
  assign bus.rd_valid    = rd_vld_q;

endmodule

// File: tb/tb_sm83_bus_responder.sv
// Random and directed bus traffic against a transaction-level model of the responder.
module tb_sm83_bus_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sm83_bus_responder_if bif();
  logic        rom_en, wram_en, wram_we;
  logic [7:0]  rom_addr, rom_dout, wram_din, wram_dout;
  logic [12:0] wram_addr;

  sm83_bus_responder dut (
    .clk(clk), .rst(rst), .bus(bif),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .wram_en(wram_en), .wram_we(wram_we), .wram_addr(wram_addr),
    .wram_din(wram_din), .wram_dout(wram_dout)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rom_val(input logic [7:0] a);
    return a * 8'd7 + 8'h31;
  endfunction

  // memory macros seen by the DUT
  logic [7:0] wram_mem [0:8191];
  always @(posedge clk) begin
    if (rom_en) rom_dout <= rom_val(rom_addr);
    if (wram_en) begin
      if (wram_we) wram_mem[wram_addr] <= wram_din;
      else         wram_dout <= wram_mem[wram_addr];
    end
  end

  // reference model: 0 none, 1 rom, 2 wram, 3 hram, 4 boot register
  logic [7:0] ref_wram [0:8191];
  logic [7:0] ref_hram [0:126];
  bit         hram_known [0:126];
  bit         boot = 1'b0;

  function automatic int region_of(input logic [15:0] a, input bit b);
    if (a < 16'h0100) return b ? 0 : 1;
    if (a >= 16'hC000 && a < 16'hFE00) return 2;
    if (a >= 16'hFF80 && a < 16'hFFFF) return 3;
    if (a == 16'hFF50) return 4;
    return 0;
  endfunction

  int          cyc = 0;
  int          p_acc = 0;
  int          p_reg = 0;
  bit          pend = 1'b0, p_wr = 1'b0;
  logic [15:0] p_addr = '0;
  logic [7:0]  p_dat = '0;
  bit          exp_busy = 1'b0, exp_vld = 1'b0, exp_known = 1'b1, in_access = 1'b0;
  logic [7:0]  exp_dat = 8'hFF;

  always @(posedge clk) begin
    cyc++;
    exp_vld = 1'b0;
    if (rst) begin
      pend = 1'b0; boot = 1'b0; exp_dat = 8'hFF; exp_known = 1'b1;
    end else if (pend) begin
      if (cyc == p_acc + 1 && p_wr) begin
        case (p_reg)
          2: ref_wram[p_addr[12:0]] = p_dat;
          3: begin ref_hram[p_addr - 16'hFF80] = p_dat; hram_known[p_addr - 16'hFF80] = 1'b1; end
          4: if (p_dat != 8'h00) boot = 1'b1;
          default: ;
        endcase
      end else if (cyc == p_acc + 2) begin
        pend = 1'b0;
        if (!p_wr) begin
          exp_vld = 1'b1; exp_known = 1'b1;
          case (p_reg)
            1: exp_dat = rom_val(p_addr[7:0]);
            2: exp_dat = ref_wram[p_addr[12:0]];
            3: begin exp_dat = ref_hram[p_addr - 16'hFF80]; exp_known = hram_known[p_addr - 16'hFF80]; end
            4: exp_dat = {7'h7F, boot};
            default: exp_dat = 8'hFF;
          endcase
        end
      end
    end else if (bif.mem_cs && (bif.mem_oe || bif.mem_we)) begin
      pend = 1'b1; p_acc = cyc; p_addr = bif.addr_bus_ext; p_dat = bif.data_bus_wr;
      p_wr = bif.mem_we; p_reg = region_of(bif.addr_bus_ext, boot);
    end
    exp_busy  = pend;
    in_access = pend && (cyc == p_acc);
  end

  always @(negedge clk) begin
    bit e_rom, e_wen, e_wwe;
    if (chk_en) begin
      e_rom = in_access && !rst && !p_wr && p_reg == 1;
      e_wen = in_access && !rst && p_reg == 2;
      e_wwe = e_wen && p_wr;
      chk("busy", 16'(bif.busy), 16'(exp_busy));
      chk("rd_valid", 16'(bif.rd_valid), 16'(exp_vld));
      if (exp_vld && exp_known) chk("data_bus_rd", 16'(bif.data_bus_rd), 16'(exp_dat));
      chk("rom_en", 16'(rom_en), 16'(e_rom));
      chk("wram_en", 16'(wram_en), 16'(e_wen));
      chk("wram_we", 16'(wram_we), 16'(e_wwe));
      if (e_rom) chk("rom_addr", 16'(rom_addr), 16'(p_addr[7:0]));
      if (e_wen) chk("wram_addr", 16'(wram_addr), 16'(p_addr[12:0]));
      if (e_wwe) chk("wram_din", 16'(wram_din), 16'(p_dat));
    end
  end

  task automatic idle_bus();
    bif.mem_cs = 1'b0; bif.mem_oe = 1'b0; bif.mem_we = 1'b0;
  endtask

  // one request, then watch ACCESS, RESP, the valid cycle and one idle cycle
  task automatic req(input logic [15:0] a, input logic [7:0] d, input logic oe, input logic we,
                     output logic [7:0] rd, output int vld_at, output int busy_n, output int rom_n);
    @(posedge clk); #2;
    bif.mem_cs = 1'b1; bif.mem_oe = oe; bif.mem_we = we; bif.addr_bus_ext = a; bif.data_bus_wr = d;
    @(posedge clk); #2;
    idle_bus();
    vld_at = -1; busy_n = 0; rom_n = 0; rd = 8'h00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bif.busy) busy_n++;
      if (rom_en) rom_n++;
      if (bif.rd_valid && vld_at < 0) begin vld_at = k; rd = bif.data_bus_rd; end
    end
  endtask

  task automatic rd_lit(input string nm, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] rd; int va, bn, rn;
    req(a, 8'h00, 1'b1, 1'b0, rd, va, bn, rn);
    chk(nm, 16'(rd), 16'(exp));
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] rd; int va, bn, rn;
    req(a, d, 1'b0, 1'b1, rd, va, bn, rn);
  endtask

  initial begin
    logic [7:0] rd;
    int va, bn, rn, n, sel;
    for (int i = 0; i < 8192; i++) begin wram_mem[i] = 8'h00; ref_wram[i] = 8'h00; end
    for (int i = 0; i < 127; i++) begin ref_hram[i] = 8'h00; hram_known[i] = 1'b0; end
    idle_bus(); bif.addr_bus_ext = '0; bif.data_bus_wr = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 16'(bif.busy), 16'd0);
    chk("rst_vld", 16'(bif.rd_valid), 16'd0);
    chk("rst_data", 16'(bif.data_bus_rd), 16'h00FF);
    chk("rst_rom_en", 16'(rom_en), 16'd0);
    chk("rst_wram_en", 16'(wram_en), 16'd0);

    req(16'h0000, 8'h00, 1'b1, 1'b0, rd, va, bn, rn);
    chk("rom_data", 16'(rd), 16'h0031);
    chk("rom_latency", 16'(va), 16'd2);
    chk("rom_busy_cycles", 16'(bn), 16'd2);
    chk("rom_en_cycles", 16'(rn), 16'd1);

    wr(16'hC123, 8'hA5);
    rd_lit("echo_read", 16'hE123, 8'hA5);

    wr(16'hFF80, 8'h5A);
    wr(16'hFFFE, 8'h3C);
    rd_lit("hram_lo", 16'hFF80, 8'h5A);
    rd_lit("hram_hi", 16'hFFFE, 8'h3C);
    rd_lit("open_ffff", 16'hFFFF, 8'hFF);

    rd_lit("boot_init", 16'hFF50, 8'hFE);
    wr(16'hFF50, 8'h00);
    rd_lit("boot_wr0", 16'hFF50, 8'hFE);
    wr(16'hFF50, 8'h01);
    rd_lit("boot_wr1", 16'hFF50, 8'hFF);
    req(16'h0000, 8'h00, 1'b1, 1'b0, rd, va, bn, rn);
    chk("rom_off_data", 16'(rd), 16'h00FF);
    chk("rom_off_en", 16'(rn), 16'd0);

    // continuous request: one acceptance every third edge
    @(posedge clk); #2;
    bif.mem_cs = 1'b1; bif.mem_oe = 1'b1; bif.mem_we = 1'b0; bif.addr_bus_ext = 16'hC000;
    n = 0;
    repeat (13) begin @(negedge clk); if (bif.rd_valid) n++; end
    @(posedge clk); #2; idle_bus();
    repeat (4) @(posedge clk);
    chk("hold_pulses", 16'(n), 16'd4);

    req(16'hC000, 8'h77, 1'b1, 1'b1, rd, va, bn, rn);
    chk("oe_we_no_vld", 16'(va), 16'hFFFF);
    rd_lit("oe_we_data", 16'hC000, 8'h77);

    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    rd_lit("boot_after_rst", 16'hFF50, 8'hFE);
    @(posedge clk); #2;
    bif.mem_cs = 1'b1; bif.mem_we = 1'b1; bif.addr_bus_ext = 16'hFF50; bif.data_bus_wr = 8'h01;
    @(posedge clk); #2; idle_bus(); rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    n = 0;
    repeat (4) begin @(negedge clk); if (bif.rd_valid) n++; end
    chk("abort_no_vld", 16'(n), 16'd0);
    rd_lit("abort_boot", 16'hFF50, 8'hFE);
    rd_lit("hram_survive", 16'hFF80, 8'h5A);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      rst = ($urandom_range(0, 199) == 0);
      bif.mem_cs = ($urandom_range(0, 3) != 0);
      bif.mem_oe = 1'($urandom_range(0, 1));
      bif.mem_we = ($urandom_range(0, 2) == 0);
      bif.data_bus_wr = 8'($urandom_range(0, 255));
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1:    bif.addr_bus_ext = 16'($urandom_range(0, 16'h00FF));
        2, 3:    bif.addr_bus_ext = 16'hC000 + 16'($urandom_range(0, 16'h1FFF));
        4:       bif.addr_bus_ext = 16'hE000 + 16'($urandom_range(0, 16'h1DFF));
        5, 6:    bif.addr_bus_ext = 16'hFF80 + 16'($urandom_range(0, 127));
        7: begin
          bif.addr_bus_ext = 16'hFF50;
          bif.data_bus_wr  = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
        end
        default: bif.addr_bus_ext = 16'($urandom_range(0, 16'hFFFF));
      endcase
    end
    @(posedge clk); #2; idle_bus(); rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
